// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial ripple-borrow subtractor. Computes diff = a - b (unsigned,
//   modulo 2^WIDTH) one bit per clock, LSB first, using the full-subtractor
//   equations on a single borrow flop. Valid/ready handshakes on both sides.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands a,b are valid
//   in_ready   block can accept operands (high only when idle)
//   a, b       minuend / subtrahend, WIDTH bits, unsigned
//   out_valid  diff/bout/zero are valid
//   out_ready  consumer accepts the result
//   diff       (a - b) mod 2^WIDTH
//   bout       borrow out of the MSB, 1 iff a < b
//   zero       1 iff diff == 0
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             br;
  logic [IDX_W-1:0] idx;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] diff_upd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The spare encoding falls through to IDLE via the default branch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (idx == LAST_IDX) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One full-subtractor slice applied to the bit selected by idx. diff_upd is
  // the result vector including the bit being written this edge, so the zero
  // flag on the final edge sees the complete difference.
  always_comb begin
    a_bit         = a_reg[idx];
    b_bit         = b_reg[idx];
    d_bit         = a_bit ^ b_bit ^ br;
    br_next       = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    diff_upd      = diff;
    diff_upd[idx] = d_bit;
  end

  // out_valid is registered from the next state so it rises together with
  // the DONE state and drops on the edge that completes the handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      br        <= 1'b0;
      idx       <= '0;
      diff      <= '0;
      bout      <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            br    <= 1'b0;
            idx   <= '0;
          end
        end
        SHIFT: begin
          diff <= diff_upd;
          br   <= br_next;
          idx  <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            bout <= br_next;
            zero <= (diff_upd == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Scoreboard bench for serial_subtractor (WIDTH=4). Stimulus pushes the
//   expected result of each accepted operation; a monitor pops and compares
//   whenever the DUT completes an output handshake.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_ready = 1'b0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain unsigned arithmetic on integers.
  function automatic exp_t refModel(input int av, input int bv);
    exp_t e;
    int   d;
    d      = (av - bv + (1 << WIDTH)) % (1 << WIDTH);
    e.diff = WIDTH'(d);
    e.bout = (av < bv);
    e.zero = (d == 0);
    return e;
  endfunction

  // Waits for in_ready, then presents one operand pair for exactly one edge.
  // Returns #1 after the accept edge.
  task automatic applyStimulus(input int av, input int bv, input bit expect_result);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      in_valid = 1'b1;
      a        = WIDTH'(av);
      b        = WIDTH'(bv);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (expect_result) sb.push_back(refModel(av, bv));
    end
  endtask

  task automatic waitDrain();
    int waited;
    waited = 0;
    while ((sb.size() != 0 || !in_ready) && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: a result is consumed when out_valid and out_ready are both high
  // at the coming edge; sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: got diff=%0d bout=%0d zero=%0d, expected no result",
                   diff, bout, zero);
        end else begin
          e = sb.pop_front();
          checkOutput("diff", 32'(diff), 32'(e.diff));
          checkOutput("bout", 32'(bout), 32'(e.bout));
          checkOutput("zero", 32'(zero), 32'(e.zero));
        end
      end
    end
  end

  // Random backpressure generator, active only while rand_ready is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(1, 0));
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int order[256];
    int tmp;
    int j;
    int waited;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_diff", 32'(diff), 32'd0);
    checkOutput("reset_bout", 32'(bout), 32'd0);
    checkOutput("reset_zero", 32'(zero), 32'd0);

    // 9-5: exact latency, then back to idle one cycle after handshake
    applyStimulus(9, 5, 1'b1);
    for (int k = 0; k < WIDTH; k++) begin
      @(negedge clk);
      checkOutput("latency_low", 32'(out_valid), 32'd0);
      checkOutput("busy_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    checkOutput("latency_high", 32'(out_valid), 32'd1);
    @(negedge clk);
    checkOutput("idle_after_hs", 32'(in_ready), 32'd1);
    checkOutput("valid_after_hs", 32'(out_valid), 32'd0);
    checkOutput("diff_held", 32'(diff), 32'd4);

    // Boundary cases
    applyStimulus(3, 7, 1'b1);
    applyStimulus(6, 6, 1'b1);
    applyStimulus(0, 15, 1'b1);
    applyStimulus(15, 0, 1'b1);
    waitDrain();

    // Backpressure in DONE with ignored in_valid pulses
    out_ready = 1'b0;
    applyStimulus(10, 3, 1'b1);
    waited = 0;
    while (!out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("bp_reached_done", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a        = WIDTH'($urandom_range(15, 0));
      b        = WIDTH'($urandom_range(15, 0));
      @(negedge clk);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_diff", 32'(diff), 32'd7);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("bp_single_hs_idle", 32'(in_ready), 32'd1);
    checkOutput("bp_single_hs_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_pending", 32'(sb.size()), 32'd0);

    // Reset during the second SHIFT edge aborts the operation
    applyStimulus(12, 1, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_diff", 32'(diff), 32'd0);
    applyStimulus(2, 1, 1'b1);
    waitDrain();

    // Exhaustive sweep in shuffled order with random backpressure
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j        = int'($urandom_range(i, 0));
      tmp      = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    rand_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(order[i] >> 4, order[i] & 15, 1'b1);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    waitDrain();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
